// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes,
// ALU/mux select encodings and the decoded control word.
package multicycle_ctrl_pkg;

  // Fixed state encoding; codes 12..15 are unused and fall back to StFetch.
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  // Instruction[31:26] opcodes
  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  // alu_op encodings
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // pc_src encodings
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // Control word decoded from the registered state alone.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       retire;      // last step of an instruction
    logic       mem_access;  // step that may stall on mem_ready
  } ctrl_t;

  // True for opcodes the controller knows how to sequence.
  function automatic logic opcode_legal(logic [5:0] op);
    return (op == OpR) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
           (op == OpAddi) || (op == OpJ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> control-word decoder for the multi-cycle controller.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // Moore decode: every field defaults to zero, each state raises its own set.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.alu_src_b  = SrcBFour;
        ctrl_o.mem_access = 1'b1;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SrcBImmSh2;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_access = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_access = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StAluWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = AluOpSub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PcSrcAluOut;
        ctrl_o.retire        = 1'b1;
      end
      StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
      end
      StAddiWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PcSrcJump;
        ctrl_o.retire   = 1'b1;
      end
      default: ctrl_o = '0;  // unused codes drive nothing
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing a multi-cycle MIPS datapath; counts retired instructions
// and flags illegal opcodes.
// Optional feature MULTICYCLE_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,        // asynchronous, active low
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [STATE_W-1:0] state,
  output logic               illegal_op,
  output logic               retired,
  output logic [CNT_W-1:0]   instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  ctrl_t            ctrl;
  logic             mem_go;     // current step may advance
  logic             retire_now;
  logic             illegal_now;

  multicycle_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_go = ~ctrl.mem_access | mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go           = 1'b1;
`endif

  assign retire_now  = ctrl.retire & mem_go;
  assign illegal_now = (state_q == StDecode) & ~opcode_legal(opcode);

  // Next-state logic: memory steps hold while mem_go is low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_go) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_go) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_go) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_comb begin
    instr_count_d = instr_count_q;
    if (retire_now) instr_count_d = instr_count_q + CNT_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StFetch;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Outputs: decoded control word, forced to zero while reset is held.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    alu_op     = AluOpAdd;
    pc_src     = PcSrcAlu;
    illegal_op = 1'b0;
    retired    = 1'b0;
    if (reset) begin
      // PC and IR only load in the cycle the fetch completes.
      pc_en      = (ctrl.pc_write & mem_go) | (ctrl.pc_write_cond & zero);
      iord       = ctrl.iord;
      mem_read   = ctrl.mem_read;
      mem_write  = ctrl.mem_write;
      ir_write   = ctrl.ir_write & mem_go;
      reg_write  = ctrl.reg_write;
      reg_dst    = ctrl.reg_dst;
      mem_to_reg = ctrl.mem_to_reg;
      alu_src_a  = ctrl.alu_src_a;
      alu_src_b  = ctrl.alu_src_b;
      alu_op     = ctrl.alu_op;
      pc_src     = ctrl.pc_src;
      illegal_op = illegal_now;
      retired    = retire_now;
    end
  end

  assign state       = STATE_W'(state_q);
  assign instr_count = instr_count_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath built from the existing PC, register file, ALU, ALU-control, memory and mux blocks.
- Each instruction is split into 3–5 clocked steps, so one memory and one ALU are shared across steps.
- Drives every datapath enable and mux select.
- Reports retired-instruction count and illegal opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- STATE_W, 4, width of state register (fixed encoding below; must be ≥4).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- opcode  in  6  Instruction[31:26] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access done (used only with feature)
- pc_en  out  1  PC register load enable = pc_write | (pc_write_cond & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  STATE_W  current state (debug)
- illegal_op  out  1  one-cycle pulse on unknown opcode
- retired  out  1  one-cycle pulse when an instruction completes
- instr_count  out  CNT_W  retired-instruction counter

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unused.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- Transitions:
  - FETCH→DECODE
  - DECODE→MEMADR (LW/SW), EXEC (R), BRANCH (BEQ), ADDIEX (ADDI), JUMP (J), else FETCH with illegal_op=1 in that cycle
  - MEMADR→MEMRD (LW) / MEMWR (SW)
  - MEMRD→MEMWB→FETCH
  - MEMWR→FETCH
  - EXEC→ALUWB→FETCH
  - ADDIEX→ADDIWB→FETCH
  - BRANCH→FETCH
  - JUMP→FETCH
  - Unused codes→FETCH on the next edge, no outputs asserted.
- Cycle counts: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
- Outputs are combinational from the registered state only; no output depends on opcode, except pc_en (which uses zero) and illegal_op.
- Output decode per state (unlisted outputs = 0):
  - FETCH: mem_read, ir_write, pc_write, alu_src_b=01
  - DECODE: alu_src_b=11
  - MEMADR: alu_src_a, alu_src_b=10
  - MEMRD: mem_read, iord
  - MEMWB: reg_write, mem_to_reg
  - MEMWR: mem_write, iord
  - EXEC: alu_src_a, alu_op=10
  - ALUWB: reg_write, reg_dst
  - BRANCH: alu_src_a, alu_op=01, pc_write_cond, pc_src=01
  - ADDIEX: alu_src_a, alu_src_b=10
  - ADDIWB: reg_write
  - JUMP: pc_write, pc_src=10
- retired pulses on the cycle before returning to FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP. It is not asserted on the illegal-opcode path.
- instr_count increments on the same clock edge that retired is sampled high. It wraps modulo 2^CNT_W.
- Reset asynchronous, applied at any point:
  - state=FETCH, instr_count=0.
  - While reset=0: all strobes/enables (pc_en, mem_read, mem_write, ir_write, reg_write, retired, illegal_op) are forced 0; selects = 0.
  - An instruction in flight is abandoned.
  - After release, the first rising edge executes FETCH.

Optional Feature:
- MULTICYCLE_MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready=1.
  - In FETCH, pc_en and ir_write are asserted only in the cycle where mem_ready=1.
  - Waits do not affect the counter.
- Undefined: mem_ready is ignored; memory accesses take exactly one cycle.

Decomposition:
- Shared package: state encoding constants, opcode constants, alu_op/alu_src_b/pc_src encodings. These are also used by the datapath and the bench.
- Sub-module: multicycle_ctrl_decode, combinational state→control-word decoder. The FSM register, next-state logic and counter remain in the top module.

Test Plan:
- Reset=0 mid-MEMRD, release → state=0, all enables 0 during reset, instr_count=0, first edge performs FETCH (ir_write=1, pc_en=1).
- Opcode 100011 (LW) → states 0,1,2,3,4; reg_write & mem_to_reg in state 4; retired once; instr_count=1.
- Opcode 000100 (BEQ): with zero=1 → pc_en=1 in BRANCH; with zero=0 → pc_en=0; both take 3 cycles.
- Opcode 111111 → DECODE→FETCH, illegal_op one-cycle pulse, instr_count unchanged.
- Mixed sequence (R, SW, ADDI, J) → 4+4+4+3=15 cycles, instr_count=4, reg_dst=1 only in ALUWB.
- With MULTICYCLE_MEM_WAIT_EN and mem_ready low for 3 cycles in MEMWR → state held at 5 with mem_write=1 for 4 cycles, then FETCH.
